// File: rtl/seven_seg_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment driver.
//   SEG_LUT : hex digit -> active-low {g,f,e,d,c,b,a} pattern
//   SEG_OFF : all segments (and dp) dark
//   AN_OFF  : no digit enabled
package seven_seg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [SEG_W:0]      SEG_OFF = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;

  // Entry 15 first so that SEG_LUT[d] yields the pattern for digit d.
  localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [SEG_W-1:0] hex_lut(input logic [3:0] digit);
    return SEG_LUT[digit];
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex-nibble to active-low 7-segment decoder.
//   digit : 4-bit hex value
//   seg_c : active-low {g,f,e,d,c,b,a}; every code 0-F is displayed
module hex_to_sseg
  import seven_seg_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = hex_lut(digit);

endmodule

// File: rtl/seven_seg.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   clk, rstn          : clock, asynchronous active-low reset
//   display_0..3       : digit values (low nibble shown; digit 0 is rightmost)
//   decplace           : index of the digit whose decimal point is lit
//   seg                : registered active-low segments, seg[7]=dp
//   an                 : registered active-low digit enables, one-hot-low
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            display_0,
  input  logic [7:0]            display_1,
  input  logic [7:0]            display_2,
  input  logic [7:0]            display_3,
  input  logic [1:0]            decplace,
  output logic [SEG_W:0]        seg,
  output logic [NUM_DIGITS-1:0] an
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           sel;
  logic [3:0]           nibble;
  logic [SEG_W-1:0]     seg_c;
  logic                 dp_n_c;
  logic                 unused_hi;

  // Upper nibbles are intentionally not displayed.
  assign unused_hi = ^{display_0[7:4], display_1[7:4], display_2[7:4], display_3[7:4]};

  // Top two counter bits pick the active digit.
  assign sel = cnt[CNT_WIDTH-1 -: 2];

  // Digit mux.
  always_comb begin
    nibble = display_0[3:0];
    case (sel)
      2'd0:    nibble = display_0[3:0];
      2'd1:    nibble = display_1[3:0];
      2'd2:    nibble = display_2[3:0];
      default: nibble = display_3[3:0];
    endcase
  end

  hex_to_sseg u_hex_to_sseg (
    .digit (nibble),
    .seg_c (seg_c)
  );

  assign dp_n_c = (sel == decplace) ? 1'b0 : 1'b1;

  // Refresh counter and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      cnt <= cnt + CNT_WIDTH'(1);
      an  <= ~(NUM_DIGITS'(1) << sel);
      seg <= {dp_n_c, seg_c};
    end
  end

endmodule

// File: tb/tb_seven_seg.sv
module tb_seven_seg;

  logic       clk;
  logic       rstn;
  logic [7:0] display_0, display_1, display_2, display_3;
  logic [1:0] decplace;
  logic [7:0] seg;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;

  // Hand-entered active-low gfedcba table.
  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] an_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  seven_seg #(.CNT_WIDTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .display_0 (display_0),
    .display_1 (display_1),
    .display_2 (display_2),
    .display_3 (display_3),
    .decplace  (decplace),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg); end
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want f", an); end
  endtask

  task automatic test_scan();
    logic [7:0] seg_exp [4];
    int d;
    seg_exp[0] = 8'hF9; seg_exp[1] = 8'hA4; seg_exp[2] = 8'h30; seg_exp[3] = 8'h99;
    display_0 = 8'h01; display_1 = 8'h02; display_2 = 8'h03; display_3 = 8'h04;
    decplace = 2'd2;
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      step();
      d = ((e - 1) / 4) % 4;
      checks++;
      if (an !== an_exp[d]) begin
        errors++; $display("FAIL scan_an edge %0d: got %h want %h", e, an, an_exp[d]);
      end
      checks++;
      if (seg !== seg_exp[d]) begin
        errors++; $display("FAIL scan_seg edge %0d: got %h want %h", e, seg, seg_exp[d]);
      end
    end
  endtask

  task automatic test_lut();
    decplace = 2'd3;
    for (int v = 0; v < 16; v++) begin
      display_0 = 8'(v);
      do_reset();
      step();
      checks++;
      if (seg !== {1'b1, lut[v]} || an !== 4'hE) begin
        errors++; $display("FAIL lut %0d: got seg=%h an=%h want seg=%h an=e", v, seg, an, {1'b1, lut[v]});
      end
    end
    display_0 = 8'hA5;
    do_reset();
    step();
    checks++;
    if (seg !== 8'h92) begin errors++; $display("FAIL upper_nibble: got %h want 92", seg); end
  endtask

  task automatic test_decplace();
    int d;
    logic dp_exp;
    display_0 = 8'h08; display_1 = 8'h08; display_2 = 8'h08; display_3 = 8'h08;
    for (int p = 0; p < 4; p++) begin
      decplace = 2'(p);
      do_reset();
      for (int e = 1; e <= 16; e++) begin
        step();
        d = (e - 1) / 4;
        dp_exp = (d == p) ? 1'b0 : 1'b1;
        checks++;
        if (seg[7] !== dp_exp || an !== an_exp[d]) begin
          errors++;
          $display("FAIL decplace %0d edge %0d: got dp=%b an=%h want dp=%b an=%h", p, e, seg[7], an, dp_exp, an_exp[d]);
        end
      end
    end
  endtask

  task automatic test_live_update();
    display_0 = 8'h01; display_1 = 8'h02; display_2 = 8'h03; display_3 = 8'h04;
    decplace = 2'd2;
    do_reset();
    step(); step();
    display_1 = 8'h0F;
    step(); step(); step();
    checks++;
    if (an !== 4'hD || seg !== 8'h8E) begin
      errors++; $display("FAIL live_update: got an=%h seg=%h want an=d seg=8e", an, seg);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) step();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      errors++; $display("FAIL reset_mid_async: got seg=%h an=%h want ff/f", seg, an);
    end
    @(negedge clk);
    rstn = 1'b1;
    step();
    checks++;
    if (an !== 4'hE) begin errors++; $display("FAIL reset_mid_restart: got %h want e", an); end
  endtask

  task automatic test_onehot();
    int bad = 0;
    display_0 = 8'($urandom); display_1 = 8'($urandom);
    display_2 = 8'($urandom); display_3 = 8'($urandom);
    decplace = 2'($urandom_range(0, 3));
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      step();
      if (i % 100 == 0) display_2 = 8'($urandom);
      if ($countones(~an) != 1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL onehot: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    rstn = 1'b0;
    display_0 = '0; display_1 = '0; display_2 = '0; display_3 = '0;
    decplace = '0;
    test_reset();
    test_scan();
    test_lut();
    test_decplace();
    test_live_update();
    test_reset_mid();
    test_onehot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
